// File: rtl/byteswap_arbiter.sv
// Round-robin shared byte-reversal unit: one registered result slot fed by NUM_REQ requesters.
// Optional completed-response counter is built only when BYTESWAP_ARB_STATS_EN is defined.
module byteswap_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cfg_bypass,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    input  logic                      rsp_ready,
    output logic [15:0]               stat_count
);

    localparam int NUM_BYTES = DATA_W / 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_any;
    logic              grant;
    logic              accept_en;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] swap_data;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (grant) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (grant) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // The slot may refill in the same cycle it drains, so rsp_ready feeds req_ready directly.
    always_comb begin
        rsp_valid = (state_q == FULL);
        accept_en = !rsp_valid || rsp_ready;
        grant     = grant_any && accept_en && resetn;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant && (grant_idx == ID_W'(i))) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    // Two passes give the wrapped search order: first indices at or above ptr, then those below it.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i] && (ID_W'(i) >= ptr_q)) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid[i] && (ID_W'(i) < ptr_q)) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + ID_W'(1);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data = sel_data | ({DATA_W{req_ready[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
        swap_data = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            swap_data[b*8 +: 8] = sel_data[(NUM_BYTES-1-b)*8 +: 8];
        end
        load_data = cfg_bypass ? sel_data : swap_data;
    end

    // Data and id only move on a grant, so they hold through stalls and plain drains.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (grant) begin
                rsp_data_q <= load_data;
                rsp_id_q   <= grant_idx;
            end
        end
    end

    assign rsp_data = rsp_data_q;
    assign rsp_id   = rsp_id_q;

`ifdef BYTESWAP_ARB_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_q <= '0;
        end else if (rsp_valid && rsp_ready && (stat_q != 16'hFFFF)) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_byteswap_arbiter.sv
// Directed bench for byteswap_arbiter with a per-cycle reference model of the arbiter and result slot.
// Stat expectations follow BYTESWAP_ARB_STATS_EN.
module tb_byteswap_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cfg_bypass;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_ready;
    logic [15:0]  stat_count;

    int passed = 0;
    int total  = 0;

    int          m_ptr   = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    int          m_id    = 0;
    int          m_stat  = 0;
    bit          model_known = 1'b0;

    logic [127:0] rr_data = {32'h13233343, 32'h12223242, 32'h11213141, 32'h10203040};

    byteswap_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_bypass (cfg_bypass),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_ready  (rsp_ready),
        .stat_count (stat_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic [3:0] v, input logic [127:0] d,
                                 input logic byp, input logic rr);
        @(negedge clk);
        resetn     = rn;
        req_valid  = v;
        req_data   = d;
        cfg_bypass = byp;
        rsp_ready  = rr;
    endtask

    // Inputs change on the falling edge; the model checks 4ns later, then steps past the next rising edge.
    always @(negedge clk) begin : compare
        int   g;
        int   idx;
        logic [3:0]  exp_ready;
        logic [31:0] word;
        #4;
        g = -1;
        idx = 0;
        if (resetn && (!m_valid || rsp_ready)) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (g < 0 && req_valid[idx[1:0]]) g = idx;
            end
        end
        exp_ready = (g < 0) ? 4'b0000 : (4'b0001 << g);
        if (model_known) begin
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            checkOutput("rsp_data", rsp_data, m_data);
            checkOutput("rsp_id", 32'(rsp_id), 32'(m_id));
            checkOutput("stat_count", 32'(stat_count), 32'(m_stat));
        end
        if (!resetn) begin
            m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = 0; m_stat = 0;
            model_known = 1'b1;
        end else begin
`ifdef BYTESWAP_ARB_STATS_EN
            if (m_valid && rsp_ready && m_stat < 65535) m_stat++;
`endif
            if (g >= 0) begin
                word    = req_data[g*32 +: 32];
                m_data  = cfg_bypass ? word : bswap(word);
                m_id    = g;
                m_valid = 1'b1;
                m_ptr   = (g + 1) % 4;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [3:0] mix_valid [10] = '{4'hF, 4'hA, 4'hA, 4'hA, 4'h1, 4'h0, 4'h6, 4'h6, 4'h9, 4'h0};
        logic       mix_ready [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        resetn = 1'b0; req_valid = '0; req_data = '0; cfg_bypass = 1'b0; rsp_ready = 1'b0;
        applyStimulus(0, 4'h0, '0, 0, 0);
        applyStimulus(0, 4'h0, '0, 0, 0);

        applyStimulus(1, 4'b0001, {96'h0, 32'h11223344}, 0, 1);
        #4 checkOutput("single_grant", 32'(req_ready), 32'h1);
        applyStimulus(1, 4'h0, '0, 0, 1);
        #4;
        checkOutput("single_valid", 32'(rsp_valid), 32'h1);
        checkOutput("single_data", rsp_data, 32'h44332211);
        checkOutput("single_id", 32'(rsp_id), 32'h0);

        applyStimulus(0, 4'h0, '0, 0, 1);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 4'hF, rr_data, 0, 1);
            #4;
            checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            if (k > 0) checkOutput("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
        end

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 4'hF, rr_data, 0, 0);
            #4;
            checkOutput("bp_ready", 32'(req_ready), 32'h0);
            checkOutput("bp_data", rsp_data, 32'h41312111);
            checkOutput("bp_id", 32'(rsp_id), 32'h1);
        end
        applyStimulus(1, 4'hF, rr_data, 0, 1);
        #4 checkOutput("bp_release_grant", 32'(req_ready), 32'h4);
        applyStimulus(1, 4'h0, rr_data, 0, 0);
        #4;
        checkOutput("bp_release_valid", 32'(rsp_valid), 32'h1);
        checkOutput("bp_release_id", 32'(rsp_id), 32'h2);
        checkOutput("bp_release_data", rsp_data, 32'h42322212);

        applyStimulus(1, 4'b0100, {32'h0, 32'hA1B2C3D4, 64'h0}, 1, 1);
        #4 checkOutput("byp_grant", 32'(req_ready), 32'h4);
        applyStimulus(1, 4'h0, '0, 0, 0);
        #4;
        checkOutput("byp_data", rsp_data, 32'hA1B2C3D4);
        checkOutput("byp_id", 32'(rsp_id), 32'h2);
        applyStimulus(1, 4'h0, '0, 1, 0);
        #4 checkOutput("byp_hold", rsp_data, 32'hA1B2C3D4);

        applyStimulus(0, 4'hF, rr_data, 0, 1);
        #4 checkOutput("rst_ready", 32'(req_ready), 32'h0);
        applyStimulus(1, 4'hF, rr_data, 0, 1);
        #4;
        checkOutput("rst_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_data", rsp_data, 32'h0);
        checkOutput("rst_first_grant", 32'(req_ready), 32'h1);
        applyStimulus(1, 4'h0, rr_data, 0, 1);
        #4;
        checkOutput("rst_first_id", 32'(rsp_id), 32'h0);
        checkOutput("rst_first_data", rsp_data, 32'h40302010);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, mix_valid[k], rr_data, k[0], mix_ready[k]);
        end

        applyStimulus(0, 4'h0, '0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 4'b0001, rr_data, 0, 1);
        applyStimulus(1, 4'h0, rr_data, 0, 1);
        applyStimulus(1, 4'h0, rr_data, 0, 1);
        #4;
`ifdef BYTESWAP_ARB_STATS_EN
        checkOutput("stat_three", 32'(stat_count), 32'd3);
`else
        checkOutput("stat_zero", 32'(stat_count), 32'd0);
`endif

        @(negedge clk);
        #6;
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
